// File: rtl/gate_sweep_checker.sv
// Truth-table sequencer for the two-input basic-gate stage: drives A/B through
// all four patterns, samples the seven gate outputs after a settle delay and reports results.
module gate_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             ny,
    input  logic             ay,
    input  logic             oy,
    input  logic             nay,
    input  logic             noy,
    input  logic             xy,
    input  logic             xny,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [6:0]       fail_vec,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_pat
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       pattern;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       observed;
    logic [6:0]       expected;
    logic [6:0]       mism;
    logic             settle_last;

    // Bit order {ny,ay,oy,nay,noy,xy,xny}; A is the pattern MSB.
    always_comb begin
        observed = {ny, ay, oy, nay, noy, xy, xny};
        expected = 7'h4D;
        case (pattern)
            2'b00: expected = 7'h4D;
            2'b01: expected = 7'h5A;
            2'b10: expected = 7'h1A;
            2'b11: expected = 7'h31;
            default: expected = 7'h4D;
        endcase
        mism        = observed ^ expected;
        settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_last) state_next = CHECK;
            CHECK:   state_next = (pattern == 2'b11) ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern          <= '0;
            cnt              <= '0;
            a_out            <= 1'b0;
            b_out            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            fail_vec         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_pat   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pattern          <= '0;
                        a_out            <= 1'b0;
                        b_out            <= 1'b0;
                        cnt              <= '0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        fail_vec         <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_pat   <= '0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                end
                CHECK: begin
                    fail_vec <= fail_vec | mism;
                    if (mism != '0) begin
                        if (err_count != '1) err_count <= err_count + ERR_W'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_pat   <= pattern;
                        end
                    end
                    if (pattern != 2'b11) begin
                        pattern          <= pattern + 2'd1;
                        {a_out, b_out}   <= pattern + 2'd1;
                        cnt              <= '0;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    // fail_vec already holds the final CHECK's mismatches here.
                    pass <= (fail_vec == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a fault-injectable ideal gate model feeds the DUT,
// and a truth-table reference predicts timing and results.
module tb_gate_sweep_checker;

    localparam int S         = 2;
    localparam int DONE_EDGE = 4 * (S + 1) + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start2;
    logic       a_out, b_out, a2, b2;
    logic       busy, done, pass, ffv;
    logic [2:0] err_count;
    logic [6:0] fail_vec;
    logic [1:0] ffp;
    logic       busy2, done2, pass2, ffv2;
    logic [1:0] err2;
    logic [6:0] fv2;
    logic [1:0] ffp2;
    logic [6:0] obs, obs2;

    logic [6:0] inv_m [4];
    logic [6:0] stk_m [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] ideal(input logic a, input logic b);
        return {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    assign obs  = (ideal(a_out, b_out) ^ inv_m[{a_out, b_out}]) & ~stk_m[{a_out, b_out}];
    assign obs2 = ~ideal(a2, b2);

    gate_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out),
        .ny(obs[6]), .ay(obs[5]), .oy(obs[4]), .nay(obs[3]), .noy(obs[2]), .xy(obs[1]), .xny(obs[0]),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec),
        .first_fail_valid(ffv), .first_fail_pat(ffp)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
        .ny(obs2[6]), .ay(obs2[5]), .oy(obs2[4]), .nay(obs2[3]), .noy(obs2[2]), .xy(obs2[1]), .xny(obs2[0]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2),
        .first_fail_valid(ffv2), .first_fail_pat(ffp2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_masks(input logic [6:0] inv, input logic [6:0] stk);
        for (int unsigned p = 0; p < 4; p++) begin
            inv_m[p] = inv;
            stk_m[p] = stk;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ab"},   32'({a_out, b_out}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err"},  32'(err_count), 32'd0);
        chk({tag, "_fv"},   32'(fail_vec), 32'd0);
        chk({tag, "_ffv"},  32'(ffv), 32'd0);
        chk({tag, "_ffp"},  32'(ffp), 32'd0);
    endtask

    // Predict results from the truth table and the injected faults.
    task automatic check_results(input string tag);
        logic [6:0] exp_fv, id, ob, m;
        int         exp_err;
        logic       exp_ffv;
        logic [1:0] exp_ffp, pv;
        exp_fv = '0; exp_err = 0; exp_ffv = 1'b0; exp_ffp = '0;
        for (int unsigned p = 0; p < 4; p++) begin
            pv = 2'(p);
            id = ideal(pv[1], pv[0]);
            ob = (id ^ inv_m[p]) & ~stk_m[p];
            m  = ob ^ id;
            exp_fv |= m;
            if (m != 0) begin
                if (exp_err < 7) exp_err++;
                if (!exp_ffv) begin
                    exp_ffv = 1'b1;
                    exp_ffp = pv;
                end
            end
        end
        chk({tag, "_err"},  32'(err_count), 32'(exp_err));
        chk({tag, "_fv"},   32'(fail_vec), 32'(exp_fv));
        chk({tag, "_ffv"},  32'(ffv), 32'(exp_ffv));
        chk({tag, "_ffp"},  32'(ffp), 32'(exp_ffp));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_fv == 0));
    endtask

    // One sweep with per-edge checks of pattern stepping, busy and the done pulse.
    task automatic run_sweep(input string tag, input bit extra_start);
        int done_cnt, done_at, pidx;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_ab0"},   32'({a_out, b_out}), 32'd0);
        done_cnt = 0;
        done_at  = -1;
        for (int k = 1; k <= DONE_EDGE + 4; k++) begin
            start = extra_start && (k == 5);
            tick();
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k <= 4 * (S + 1)) begin
                pidx = k / (S + 1);
                if (pidx > 3) pidx = 3;
                chk({tag, "_ab"}, 32'({a_out, b_out}), 32'(pidx));
            end
            chk({tag, "_busy"}, 32'(busy), 32'(k < DONE_EDGE));
        end
        chk({tag, "_ndone"},  32'(done_cnt), 32'd1);
        chk({tag, "_doneat"}, 32'(done_at), 32'(DONE_EDGE));
        chk({tag, "_abhold"}, 32'({a_out, b_out}), 32'd3);
    endtask

    initial begin
        int seen, nd;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        set_masks('0, '0);
        tick();
        tick();
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_outputs_zero("idle");

        // Ideal gates
        run_sweep("ideal", 1'b0);
        check_results("ideal");

        // AND stuck at 0: only pattern 11 differs
        set_masks('0, 7'h20);
        run_sweep("and_sa0", 1'b0);
        check_results("and_sa0");
        chk("and_sa0_fv_lit", 32'(fail_vec), 32'h20);
        chk("and_sa0_ffp_lit", 32'(ffp), 32'd3);

        // XOR inverted: every pattern differs
        set_masks(7'h02, '0);
        run_sweep("xor_inv", 1'b0);
        check_results("xor_inv");
        chk("xor_inv_err_lit", 32'(err_count), 32'd4);

        // Fresh sweep clears old results; a start while busy is ignored
        set_masks('0, '0);
        run_sweep("restart", 1'b1);
        check_results("restart");

        // Randomized per-pattern faults
        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned p = 0; p < 4; p++) begin
                inv_m[p] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
                stk_m[p] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            end
            run_sweep("rand", 1'b0);
            check_results("rand");
        end

        // Saturation with ERR_W=2 and all outputs inverted
        @(negedge clk);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            tick();
            if (done2) seen = 1;
        end
        chk("sat_done_seen", 32'(seen), 32'd1);
        chk("sat_err",  32'(err2), 32'd3);
        chk("sat_fv",   32'(fv2), 32'h7F);
        chk("sat_pass", 32'(pass2), 32'd0);
        chk("sat_ffv",  32'(ffv2), 32'd1);
        chk("sat_ffp",  32'(ffp2), 32'd0);

        // start held high re-triggers right after each DONE
        set_masks('0, '0);
        nd = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            tick();
            if (k == 28) start = 1'b0;
            if (done) begin
                nd++;
                chk("hold_done_edge", 32'(k % (DONE_EDGE + 1)), 32'(DONE_EDGE));
            end
        end
        chk("hold_ndone", 32'(nd), 32'd3);
        chk("hold_pass",  32'(pass), 32'd1);

        // Reset during pattern 10 settle
        set_masks(7'h11, '0);
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        chk("rst_mid_ab", 32'({a_out, b_out}), 32'd2);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) nd++;
        end
        chk("rst_nodone", 32'(nd), 32'd0);
        check_outputs_zero("rst_after");
        set_masks('0, '0);
        run_sweep("post_rst", 1'b0);
        check_results("post_rst");
        chk("post_rst_pass", 32'(pass), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
